// File: rtl/pixbuf_pkg.sv
// Shared types and default sizing for the pixel stream buffer.
package pixbuf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RECV  = 2'd2,
        DRAIN = 2'd3
    } pixbuf_state_t;

    localparam int DEF_BURST_LEN   = 8;
    localparam int DEF_DEPTH       = 64;
    localparam int DEF_FRAME_WORDS = 76800;

endpackage

// File: rtl/pixbuf_fifo_mem.sv
// Simple dual-port RAM, one write and one registered read port, shaped for block-RAM inference.
module pixbuf_fifo_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read returns the old word when the same address is written in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pixel_stream_buffer.sv
// Burst-reserving FIFO between the SDRAM read stream and the pixel side.
// Define PIXBUF_STATS_EN to add the drop_count / starve_count outputs.
module pixel_stream_buffer
    import pixbuf_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic                   ck,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   burst_req,
    input  logic                   burst_ack,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   frame_done,
    output logic                   overflow,
    output logic                   underflow
`ifdef PIXBUF_STATS_EN
    ,
    output logic [15:0]            drop_count,
    output logic [15:0]            starve_count
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int FW_W  = $clog2(FRAME_WORDS + 1);
    localparam int BC_W  = $clog2(BURST_LEN + 1);

    localparam logic [LVL_W-1:0] LVL_LIMIT   = LVL_W'(DEPTH - BURST_LEN);
    localparam logic [FW_W-1:0]  FETCH_LIMIT = FW_W'(FRAME_WORDS - BURST_LEN);
    localparam logic [FW_W-1:0]  LAST_WORD   = FW_W'(FRAME_WORDS - 1);
    localparam logic [BC_W-1:0]  LAST_BEAT   = BC_W'(BURST_LEN - 1);

    if ((FRAME_WORDS % BURST_LEN) != 0) begin : g_chk_frame
        $error("FRAME_WORDS must be a whole number of bursts");
    end
    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 2 * BURST_LEN)) begin : g_chk_depth
        $error("DEPTH must be a power of two and at least 2*BURST_LEN");
    end

    pixbuf_state_t     r_state, w_state_next;
    logic [BC_W-1:0]   r_burst_cnt, w_burst_cnt_next;
    logic [AW:0]       r_wptr, r_rptr;
    logic [FW_W-1:0]   r_fetched;
    logic              r_frame_active, r_frame_done, r_overflow, r_underflow;
    logic              r_rd_valid, r_rd_seen;
    logic [LVL_W-1:0]  w_level;
    logic              w_full, w_empty, w_pop, w_starve, w_wr, w_ovf, w_idle_stray, w_last_word;
    logic [DATA_W-1:0] w_mem_q;

    assign w_level      = r_wptr - r_rptr;
    assign w_full       = w_level[AW];
    assign w_empty      = (w_level == '0);
    assign w_pop        = rd_en && !w_empty && !frame_start;
    assign w_starve     = rd_en && w_empty && !frame_start;
    assign w_wr         = in_valid && (r_state == RECV) && !frame_start && (!w_full || w_pop);
    assign w_ovf        = in_valid && !frame_start && w_full && !w_pop && (r_state != DRAIN);
    assign w_idle_stray = in_valid && !frame_start && (r_state == IDLE);
    assign w_last_word  = w_wr && (r_fetched == LAST_WORD);

    always_comb begin
        w_state_next     = r_state;
        w_burst_cnt_next = r_burst_cnt;
        case (r_state)
            IDLE: begin
                if (!frame_start && r_frame_active && (w_level <= LVL_LIMIT) &&
                    (r_fetched <= FETCH_LIMIT)) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (burst_ack) begin
                    w_burst_cnt_next = '0;
                    w_state_next     = frame_start ? DRAIN : RECV;
                end else if (frame_start) begin
                    w_state_next = IDLE;
                end
            end
            RECV, DRAIN: begin
                // Every beat of the in-flight burst is counted, whether kept or discarded.
                if (in_valid) begin
                    w_burst_cnt_next = r_burst_cnt + 1'b1;
                end
                if (in_valid && (r_burst_cnt == LAST_BEAT)) begin
                    w_state_next = IDLE;
                end else if (frame_start) begin
                    w_state_next = DRAIN;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_burst_cnt    <= '0;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_fetched      <= '0;
            r_frame_active <= 1'b0;
            r_frame_done   <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_rd_seen      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_burst_cnt  <= w_burst_cnt_next;
            r_rd_valid   <= w_pop;
            r_frame_done <= w_last_word;
            if (w_pop) begin
                r_rd_seen <= 1'b1;
            end
            if (frame_start) begin
                r_wptr         <= '0;
                r_rptr         <= '0;
                r_fetched      <= '0;
                r_overflow     <= 1'b0;
                r_underflow    <= 1'b0;
                r_frame_active <= 1'b1;
            end else begin
                if (w_wr) begin
                    r_wptr    <= r_wptr + 1'b1;
                    r_fetched <= r_fetched + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                if (w_ovf) begin
                    r_overflow <= 1'b1;
                end
                if (w_starve) begin
                    r_underflow <= 1'b1;
                end
                if (w_last_word) begin
                    r_frame_active <= 1'b0;
                end
            end
        end
    end

    pixbuf_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (ck),
        .i_we    (w_wr),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (in_data),
        .i_re    (w_pop),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (w_mem_q)
    );

`ifdef PIXBUF_STATS_EN
    logic [15:0] r_drop_cnt, r_starve_cnt;

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            r_drop_cnt   <= '0;
            r_starve_cnt <= '0;
        end else if (frame_start) begin
            r_drop_cnt   <= '0;
            r_starve_cnt <= '0;
        end else begin
            if ((w_ovf || w_idle_stray) && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_starve && (r_starve_cnt != 16'hFFFF)) begin
                r_starve_cnt <= r_starve_cnt + 16'd1;
            end
        end
    end

    assign drop_count   = r_drop_cnt;
    assign starve_count = r_starve_cnt;
`endif

    // RAM output register has no reset, so it is masked until the first pop after reset.
    assign rd_data    = r_rd_seen ? w_mem_q : '0;
    assign rd_valid   = r_rd_valid;
    assign burst_req  = (r_state == REQ);
    assign level      = w_level;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: doc/pixel_stream_buffer.md
Name: pixel_stream_buffer

Overview:
- Downstream consumer of the SDRAM read controller's word stream (dq_ready / dq).
- Buffers image words in a FIFO, requests new SDRAM bursts only when space for a full burst exists, and presents words to the pixel/display side through a registered read port.
- Tracks how many words of the current frame have been fetched and stops requesting once the frame is complete.

Parameters:
- DATA_W, 16, word width (matches SDRAM dq)
- DEPTH, 64, FIFO depth in words; power of two, at least 2*BURST_LEN
- BURST_LEN, 8, words delivered per SDRAM burst
- FRAME_WORDS, 76800, words per frame (320x240)

Ports:
- ck  in  1  clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse: flush and begin a new frame
- in_valid  in  1  word strobe from SDRAM controller (dq_ready)
- in_data  in  DATA_W  word from SDRAM controller (dq)
- burst_req  out  1  request one burst; held until burst_ack
- burst_ack  in  1  one-cycle pulse: controller accepted the request
- rd_en  in  1  pop request from pixel side
- rd_data  out  DATA_W  registered popped word
- rd_valid  out  1  rd_data valid this cycle
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- frame_done  out  1  one-cycle pulse when word count reaches FRAME_WORDS
- overflow  out  1  sticky; a word arrived while full
- underflow  out  1  sticky; rd_en while empty

Behaviour:
- Reset: all outputs 0; FIFO empty; pointers, frame counter and burst counter 0; FSM in IDLE.
- FSM states:
  - IDLE: if frame_active, level + BURST_LEN <= DEPTH, and fetched + BURST_LEN <= FRAME_WORDS, go to REQ.
  - REQ: burst_req=1; on burst_ack go to RECV with burst counter=0.
  - RECV: each in_valid writes in_data and increments the burst counter and frame word counter; after BURST_LEN words go to IDLE.
  - DRAIN: discard in_valid words until BURST_LEN of the in-flight burst have arrived, then go to IDLE.
- Space is reserved at request time, so overflow indicates a controller protocol error (more than BURST_LEN words). The extra word is dropped and the count is unchanged.
- frame_active: set by frame_start, cleared when frame_done fires.
- frame_done: pulses on the cycle the FRAME_WORDS-th word is written.
- Final partial burst: FRAME_WORDS not divisible by BURST_LEN is unsupported; enforced by an elaboration-time check.
- frame_start:
  - Clears FIFO, counters and sticky flags in the same cycle.
  - In IDLE or REQ: go to IDLE and drop burst_req.
  - In RECV: go to DRAIN with the remaining count preserved.
  - frame_start in REQ coincident with burst_ack: go to DRAIN with count 0.
- Read port:
  - rd_en with level>0: rd_data/rd_valid update on the next edge; latency 1; rd_valid=0 otherwise.
  - rd_data holds its last value when not popping.
  - rd_en while empty: no pop, underflow set. A word written in the same cycle is not visible; no fall-through.
- Simultaneous write and read:
  - Full: both occur; level unchanged.
  - Empty: only the write occurs; underflow set.
- Pointers wrap modulo DEPTH. level is the registered write count minus read count.
- Asynchronous reset mid-burst: immediate return to reset state. Words of the aborted burst that arrive afterwards in IDLE are ignored, with overflow not set.

Optional Feature:
- PIXBUF_STATS_EN defined:
  - Adds outputs drop_count[15:0] (words dropped on overflow, or ignored in IDLE) and starve_count[15:0] (rd_en while empty).
  - Both saturate at 16'hFFFF and clear on reset and frame_start.
- Not defined: ports and counters are absent; sticky flags are unchanged.

Decomposition:
- Package pixbuf_pkg: FSM state enum (IDLE, REQ, RECV, DRAIN) and default constants for BURST_LEN, DEPTH and FRAME_WORDS.
- One sub-module, pixbuf_fifo_mem: simple dual-port RAM, DEPTH x DATA_W, synchronous read, to infer M10K.

Test Plan:
- Reset, then frame_start with DEPTH=64 -> burst_req rises within 2 cycles. Ack, send 8 words 0x0001..0x0008 -> level=8, FSM back in IDLE, second burst_req issued.
- Fill to level=64 without reads -> burst_req stays 0. Pop 8 words -> burst_req reasserts; popped data is in order 0x0001.. with rd_valid exactly 1 cycle after each rd_en.
- FRAME_WORDS=32 -> frame_done pulses once on the 32nd write; no further burst_req until the next frame_start.
- frame_start after 3 words of a burst -> level=0 next cycle; the remaining 5 words are discarded in DRAIN; then IDLE and a new request.
- rd_en on empty with simultaneous in_valid -> rd_valid=0, underflow=1, level=1. A 9th word in one burst at level=64 -> overflow=1, level stays 64 (drop_count=1 with PIXBUF_STATS_EN).
- Assert reset mid-RECV -> all outputs 0 immediately. Late in_valid words ignored, level stays 0, overflow stays 0.
